// File: rtl/memory_bank_nr1w.sv
// rtl/memory_bank_nr1w.sv - multi-read, single byte-masked write memory bank (option: MEMORY_BANK_NR1W_PARITY_EN)
module memory_bank_nr1w #(
    parameter int          SIZE        = 1024,
    parameter int          ADDR_WIDTH  = $clog2(SIZE),
    parameter int          COL_WIDTH   = 8,
    parameter int          NB_COL      = 4,
    parameter int          NB_RPORT    = 2,
    parameter logic [39:0] WRITE_FIRST = 40'("TRUE"),
    parameter int          OUT_REG     = 0,
    localparam int         DATA_WIDTH  = NB_COL * COL_WIDTH
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [NB_RPORT-1:0]                    read_enable,
    input  logic [NB_RPORT-1:0][ADDR_WIDTH-1:0]    read_address,
    input  logic [NB_COL-1:0]                      write_enable,
    input  logic [ADDR_WIDTH-1:0]                  write_address,
    input  logic [DATA_WIDTH-1:0]                  write_data,
    output logic [NB_RPORT-1:0]                    read_valid,
    output logic [NB_RPORT-1:0][DATA_WIDTH-1:0]    read_data,
    output logic [NB_RPORT-1:0]                    read_parity_error
);

    localparam bit WF_EN = (WRITE_FIRST == 40'("TRUE"));

`ifdef MEMORY_BANK_NR1W_PARITY_EN
    // each column carries one even-parity bit above its data
    localparam int SW = COL_WIDTH + 1;
`else
    localparam int SW = COL_WIDTH;
`endif

    // raw stage-1 array read result, per port and column (data plus optional parity)
    logic [NB_RPORT-1:0][NB_COL-1:0][SW-1:0] ram_word;

    for (genvar c = 0; c < NB_COL; c++) begin : g_col
        logic [SW-1:0]               mem_q [SIZE];
        logic [NB_RPORT-1:0][SW-1:0] rd_q;
        logic [SW-1:0]               wr_word;

`ifdef MEMORY_BANK_NR1W_PARITY_EN
        assign wr_word = {^write_data[c*COL_WIDTH +: COL_WIDTH], write_data[c*COL_WIDTH +: COL_WIDTH]};
`else
        assign wr_word = write_data[c*COL_WIDTH +: COL_WIDTH];
`endif

        // column write; storage has no reset so it maps onto block RAM
        always_ff @(posedge clock) begin
            if (write_enable[c]) begin
                mem_q[write_address] <= wr_word;
            end
        end

        // registered per-port read; returns pre-write content on collision
        always_ff @(posedge clock) begin
            for (int p = 0; p < NB_RPORT; p++) begin
                if (read_enable[p]) begin
                    rd_q[p] <= mem_q[read_address[p]];
                end
            end
        end

        for (genvar p = 0; p < NB_RPORT; p++) begin : g_rd
            assign ram_word[p][c] = rd_q[p];
        end
    end

`ifndef MEMORY_BANK_NR1W_PARITY_EN
    assign read_parity_error = '0;
`endif

    for (genvar p = 0; p < NB_RPORT; p++) begin : g_port
        logic                  coll;
        logic                  valid1_q;
        logic                  has1_q;
        logic [NB_COL-1:0]     cmask_q;
        logic [DATA_WIDTH-1:0] fwd_q;
        logic [DATA_WIDTH-1:0] merged;
        logic                  perr1;

        assign coll = read_enable[p] && (|write_enable) && (read_address[p] == write_address);

        // stage 1 control: valid, "has delivered data" flag, column forward mask and word
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                valid1_q <= 1'b0;
                has1_q   <= 1'b0;
                cmask_q  <= '0;
                fwd_q    <= '0;
            end else begin
                valid1_q <= read_enable[p];
                if (read_enable[p]) begin
                    has1_q  <= 1'b1;
                    cmask_q <= (coll && WF_EN) ? write_enable : '0;
                    fwd_q   <= write_data;
                end
            end
        end

        // per-column merge of forwarded write data over array data, plus parity check
        always_comb begin
            merged = '0;
            perr1  = 1'b0;
            for (int c = 0; c < NB_COL; c++) begin
                merged[c*COL_WIDTH +: COL_WIDTH] = cmask_q[c] ? fwd_q[c*COL_WIDTH +: COL_WIDTH]
                                                             : ram_word[p][c][COL_WIDTH-1:0];
`ifdef MEMORY_BANK_NR1W_PARITY_EN
                if (!cmask_q[c] && (^ram_word[p][c])) begin
                    perr1 = 1'b1;
                end
`endif
            end
        end

        if (OUT_REG != 0) begin : g_oreg
            logic                  valid2_q;
            logic                  perr2_q;
            logic [DATA_WIDTH-1:0] data2_q;

            // optional output stage with its own valid; holds data between results
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    valid2_q <= 1'b0;
                    perr2_q  <= 1'b0;
                    data2_q  <= '0;
                end else begin
                    valid2_q <= valid1_q;
                    perr2_q  <= valid1_q & perr1;
                    if (valid1_q) begin
                        data2_q <= merged;
                    end
                end
            end

            assign read_valid[p] = valid2_q;
            assign read_data[p]  = data2_q;
`ifdef MEMORY_BANK_NR1W_PARITY_EN
            assign read_parity_error[p] = perr2_q;
`endif
        end else begin : g_noreg
            assign read_valid[p] = valid1_q;
            assign read_data[p]  = has1_q ? merged : '0;
`ifdef MEMORY_BANK_NR1W_PARITY_EN
            assign read_parity_error[p] = valid1_q & perr1;
`endif
        end
    end

endmodule

// File: tb/tb_memory_bank_nr1w.sv
// tb/tb_memory_bank_nr1w.sv - directed self-checking bench for memory_bank_nr1w
module tb_memory_bank_nr1w;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      re;
    logic [1:0][3:0] ra;
    logic [3:0]      we;
    logic [3:0]      wa;
    logic [31:0]     wd;

    logic [1:0]       rv0, rv1, pe0, pe1;
    logic [1:0][31:0] rd0, rd1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    memory_bank_nr1w #(.SIZE(16), .WRITE_FIRST(40'("TRUE")), .OUT_REG(0)) d0 (
        .clock(clk), .reset(rst), .read_enable(re), .read_address(ra),
        .write_enable(we), .write_address(wa), .write_data(wd),
        .read_valid(rv0), .read_data(rd0), .read_parity_error(pe0)
    );

    memory_bank_nr1w #(.SIZE(16), .WRITE_FIRST(40'("FALSE")), .OUT_REG(1)) d1 (
        .clock(clk), .reset(rst), .read_enable(re), .read_address(ra),
        .write_enable(we), .write_address(wa), .write_data(wd),
        .read_valid(rv1), .read_data(rd1), .read_parity_error(pe1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        re = '0; we = '0;
    endtask

    initial begin
        rst = 1'b1; re = '0; ra = '0; we = '0; wa = '0; wd = '0;
        #1;
        check("rst_rv0", {30'd0, rv0}, 32'd0);
        check("rst_rv1", {30'd0, rv1}, 32'd0);
        check("rst_rd0", rd0[0] | rd0[1], 32'd0);
        check("rst_rd1", rd1[0] | rd1[1], 32'd0);
        check("rst_pe",  {28'd0, pe0, pe1}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // basic write then read, latency 1 and 2
        we = 4'hF; wa = 4'd5; wd = 32'hDEADBEEF;
        tick();
        idle(); re = 2'b01; ra[0] = 4'd5;
        tick();
        idle();
        check("t1_rv0_l1", {31'd0, rv0[0]}, 32'd1);
        check("t1_rd0_l1", rd0[0], 32'hDEADBEEF);
        check("t1_rv1_early", {31'd0, rv1[0]}, 32'd0);
        tick();
        check("t1_rv0_done", {31'd0, rv0[0]}, 32'd0);
        check("t1_rd0_hold", rd0[0], 32'hDEADBEEF);
        check("t1_rv1_l2", {31'd0, rv1[0]}, 32'd1);
        check("t1_rd1_l2", rd1[0], 32'hDEADBEEF);
        tick();
        check("t1_rv1_done", {31'd0, rv1[0]}, 32'd0);

        // byte-masked collision
        we = 4'hF; wa = 4'd7; wd = 32'h11223344;
        tick();
        we = 4'b0101; wa = 4'd7; wd = 32'hAABBCCDD; re = 2'b10; ra[1] = 4'd7;
        tick();
        idle();
        check("t2_wf_rv", {31'd0, rv0[1]}, 32'd1);
        check("t2_wf_data", rd0[1], 32'h11BB33DD);
        re = 2'b01; ra[0] = 4'd7;
        tick();
        idle();
        check("t2_nwf_rv", {31'd0, rv1[1]}, 32'd1);
        check("t2_nwf_data", rd1[1], 32'h11223344);
        check("t2_ram_after", rd0[0], 32'h11BB33DD);
        tick();

        // streaming reads against streaming writes
        we = 4'hF; wa = 4'd3; wd = 32'h33333333;
        tick();
        we = 4'hF; wa = 4'd9; wd = 32'h0;
        tick();
        for (int i = 0; i < 16; i++) begin
            re = 2'b11; ra[0] = 4'd3; ra[1] = 4'd9;
            we = 4'hF; wa = 4'd9; wd = 32'(i + 1);
            tick();
            check("t3_d0_rv", {30'd0, rv0}, 32'd3);
            check("t3_d0_p0", rd0[0], 32'h33333333);
            check("t3_d0_p1", rd0[1], 32'(i + 1));
            if (i > 0) begin
                check("t3_d1_rv", {30'd0, rv1}, 32'd3);
                check("t3_d1_p0", rd1[0], 32'h33333333);
                check("t3_d1_p1", rd1[1], 32'(i - 1));
            end
        end
        idle();
        tick();
        check("t3_d1_last_rv", {30'd0, rv1}, 32'd3);
        check("t3_d1_last_p1", rd1[1], 32'd15);
        check("t3_d0_idle_rv", {30'd0, rv0}, 32'd0);
        tick();

        // reset with reads in flight
        re = 2'b11; ra[0] = 4'd3; ra[1] = 4'd5;
        tick();
        idle();
        rst = 1'b1;
        #1;
        check("t4_rst_rv0", {30'd0, rv0}, 32'd0);
        check("t4_rst_rv1", {30'd0, rv1}, 32'd0);
        check("t4_rst_rd1", rd1[0] | rd1[1], 32'd0);
        check("t4_rst_rd0", rd0[0] | rd0[1], 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_post_rv", {28'd0, rv0, rv1}, 32'd0);
            check("t4_post_rd", rd1[0] | rd1[1] | rd0[0] | rd0[1], 32'd0);
        end

        // parity
        we = 4'hF; wa = 4'd2; wd = 32'h0F0F0F0F;
        tick();
        idle();
`ifdef MEMORY_BANK_NR1W_PARITY_EN
        d0.g_col[1].mem_q[2] = d0.g_col[1].mem_q[2] ^ 9'h001;
        re = 2'b01; ra[0] = 4'd2;
        tick();
        idle();
        check("t5_pe_rv", {31'd0, rv0[0]}, 32'd1);
        check("t5_pe_flag", {31'd0, pe0[0]}, 32'd1);
        tick();
        check("t5_pe_clear", {31'd0, pe0[0]}, 32'd0);
        we = 4'hF; wa = 4'd2; wd = 32'h0F0F0F0F; re = 2'b01; ra[0] = 4'd2;
        tick();
        idle();
        check("t5_coll_rv", {31'd0, rv0[0]}, 32'd1);
        check("t5_coll_pe", {31'd0, pe0[0]}, 32'd0);
        check("t5_coll_rd", rd0[0], 32'h0F0F0F0F);
`else
        re = 2'b11; ra[0] = 4'd2; ra[1] = 4'd2;
        tick();
        idle();
        check("t5_nopar_rv", {30'd0, rv0}, 32'd3);
        check("t5_nopar_rd", rd0[1], 32'h0F0F0F0F);
        check("t5_nopar_pe0", {30'd0, pe0}, 32'd0);
        tick();
        check("t5_nopar_pe1", {30'd0, pe1}, 32'd0);
`endif
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
